g07_slave_responder: RTL
========================

Name: g07_slave_responder

Overview:
Bus slave endpoint for the g07 shared bus: the responder side of the arbiter's slave port (en/addr in, Tdone out).
- Claims one address window [BASE_ADDR : LIMIT_ADDR] and backs it with a word-addressed register file.
- Inserts a programmable number of wait states, then pulses Tdone so the arbiter releases the granted master.
- One instance per slave slot (s7..s14).

Parameters:
- ADDR_W, 64, bus address width.
- DATA_W, 32, data width.
- BASE_ADDR, 64'hFFFE7637, first address claimed.
- LIMIT_ADDR, 64'hFFFE7643, last address claimed (inclusive); LIMIT_ADDR-BASE_ADDR+1 <= DEPTH, checked by elaboration assertion.
- DEPTH, 16, storage words.
- WAIT_CYC, 2, wait states between acceptance and Tdone (0..15).

Ports:
- sysClk  in  1  bus clock; block logic on posedge.
- Breset  in  1  reset, asynchronous, active-low.
- en  in  1  slave enable from arbiter; high for the whole transaction.
- addr  in  ADDR_W  transaction address, valid while en=1.
- rw  in  1  1=write, 0=read.
- wdata  in  DATA_W  write data, valid while en=1.
- rdata  out  DATA_W  read data.
- Tdone  out  1  transaction-done pulse to arbiter.
- err  out  1  error flag, qualified by Tdone.
- busy  out  1  high in any non-IDLE state.

Behaviour:
- Reset (Breset=0, async): state=IDLE, Tdone=0, err=0, rdata=0, busy=0, wait counter=0. Storage not cleared. Reset mid-transaction aborts with no write and no Tdone.
- FSM states: IDLE, ACCESS, DONE, HOLD.
- IDLE: on edge with en=1, latch addr/rw/wdata, cnt<=WAIT_CYC, go ACCESS. Later changes on addr/wdata/rw are ignored.
- ACCESS: cnt>0 -> cnt-1. cnt==0 -> go DONE.
  - Write in range: commits at that same edge.
  - Read in range: rdata loads mem[idx] at that same edge.
  - en low in ACCESS (arbiter abort): back to IDLE, no write, rdata unchanged, no Tdone.
- DONE: Tdone=1 for exactly one cycle, then HOLD.
  - err=1 with Tdone iff latched addr < BASE_ADDR or > LIMIT_ADDR.
  - Out-of-range: no storage access; on read, rdata forced to {DATA_W{1'b1}}.
- HOLD: Tdone=0, err=0; stay until en=0, then IDLE.
  - Prevents a second transaction on the same held en.
  - en must be seen low for at least one edge between transactions.
- Latency: en sampled at edge N -> Tdone high in cycle after edge N+WAIT_CYC+1. WAIT_CYC=0 gives Tdone after 2 edges.
- Index: idx = (latched addr - BASE_ADDR), truncated to $clog2(DEPTH) bits; subtraction at ADDR_W bits, unsigned.
- Range checks are inclusive at both ends: BASE_ADDR and LIMIT_ADDR are legal; BASE_ADDR-1 and LIMIT_ADDR+1 are errors.
- rdata holds its last value except on a completed read. Writes never change rdata.
- Tdone and err are registered outputs; no combinational path from en/addr.
- busy=1 in ACCESS, DONE and HOLD.

Decomposition:
- Shared package g07_bus_pkg:
  - resp_state_t enum {IDLE, ACCESS, DONE, HOLD}.
  - addr_t / data_t typedefs.
  - The 15-entry slave window BASE/LIMIT localparam table, so instantiations take their window from the package.
- Sub-module g07_slave_mem: single-port synchronous register file.
  - Ports: clk, we, idx, wdata, rdata; 1-cycle read.
  - Responder issues the read one edge before the DONE transition.

Test Plan:
- Default params; write 32'hDEADBEEF to 64'hFFFE7637, then read it back -> both Tdone pulses one cycle wide, 4 edges after en rise, err=0; read gives rdata=32'hDEADBEEF.
- Write 32'h0000A5A5 to LIMIT 64'hFFFE7643, then read it back -> rdata=32'h0000A5A5, err=0. Read 64'hFFFE7644 -> Tdone with err=1, rdata=32'hFFFFFFFF, storage unchanged.
- en held high for 10 cycles after Tdone -> exactly one Tdone, busy=1 until en drops, IDLE one edge after en=0.
- Write to 64'hFFFE7638 with en dropped after 1 ACCESS cycle -> no Tdone; subsequent read of 64'hFFFE7638 returns the previous value.
- Breset pulsed low in ACCESS during a write of 32'h12345678 -> Tdone=0, err=0, busy=0 immediately; no write occurs; next transaction completes normally.
- WAIT_CYC=0 and WAIT_CYC=15 instances -> Tdone after 2 and 17 edges respectively. Back-to-back transactions separated by a single en-low cycle both complete.

Source files
------------

// File: rtl/g07_bus_pkg.sv
// Shared types and slave address map for the g07 shared bus.
// Each slave slot owns a 13-word window; slots are spaced 16 addresses apart.
package g07_bus_pkg;

    localparam int BUS_ADDR_W   = 64;
    localparam int BUS_DATA_W   = 32;
    localparam int NUM_SLOTS    = 15;
    localparam int DEFAULT_SLOT = 7;
    localparam int CNT_W        = 4;
    localparam int MAX_WAIT     = 15;

    typedef logic [BUS_ADDR_W-1:0] addr_t;
    typedef logic [BUS_DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2,
        HOLD   = 2'd3
    } resp_state_t;

    // Inclusive [base : limit] window for each slot.
    localparam addr_t SLOT_BASE [NUM_SLOTS] = '{
        64'hFFFE75C7, 64'hFFFE75D7, 64'hFFFE75E7, 64'hFFFE75F7, 64'hFFFE7607,
        64'hFFFE7617, 64'hFFFE7627, 64'hFFFE7637, 64'hFFFE7647, 64'hFFFE7657,
        64'hFFFE7667, 64'hFFFE7677, 64'hFFFE7687, 64'hFFFE7697, 64'hFFFE76A7
    };

    localparam addr_t SLOT_LIMIT [NUM_SLOTS] = '{
        64'hFFFE75D3, 64'hFFFE75E3, 64'hFFFE75F3, 64'hFFFE7603, 64'hFFFE7613,
        64'hFFFE7623, 64'hFFFE7633, 64'hFFFE7643, 64'hFFFE7653, 64'hFFFE7663,
        64'hFFFE7673, 64'hFFFE7683, 64'hFFFE7693, 64'hFFFE76A3, 64'hFFFE76B3
    };

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/g07_slave_responder_if.sv
// Arbiter-to-slave port of the g07 bus: request side driven by the arbiter,
// completion side driven by the responder.
interface g07_slave_responder_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 32
);
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic              rw;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              Tdone;
    logic              err;
    logic              busy;

    modport master (
        output en, addr, rw, wdata,
        input  rdata, Tdone, err, busy
    );

    modport slave (
        input  en, addr, rw, wdata,
        output rdata, Tdone, err, busy
    );
endinterface

// File: rtl/g07_slave_mem.sv
// Single-port synchronous register file with a registered (1-cycle) read.
// Contents are intentionally not reset.
module g07_slave_mem
    import g07_bus_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int IDX_W = idx_width(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        rdata <= mem[idx];
    end

endmodule

// File: rtl/g07_slave_responder.sv
// g07 bus slave endpoint: claims one address window, inserts WAIT_CYC wait
// states, then pulses Tdone (with err for out-of-window accesses).
module g07_slave_responder
    import g07_bus_pkg::*;
#(
    parameter int                ADDR_W     = 64,
    parameter int                DATA_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = SLOT_BASE[DEFAULT_SLOT][ADDR_W-1:0],
    parameter logic [ADDR_W-1:0] LIMIT_ADDR = SLOT_LIMIT[DEFAULT_SLOT][ADDR_W-1:0],
    parameter int                DEPTH      = 16,
    parameter int                WAIT_CYC   = 2
) (
    input  logic                  sysClk,
    input  logic                  Breset,
    g07_slave_responder_if.slave  bus
);

    localparam int IDX_W = idx_width(DEPTH);

    if (LIMIT_ADDR < BASE_ADDR) begin : g_bad_order
        $error("g07_slave_responder: LIMIT_ADDR is below BASE_ADDR");
    end
    if ((LIMIT_ADDR - BASE_ADDR) >= ADDR_W'(DEPTH)) begin : g_bad_window
        $error("g07_slave_responder: address window larger than DEPTH");
    end
    if ((WAIT_CYC < 0) || (WAIT_CYC > MAX_WAIT)) begin : g_bad_wait
        $error("g07_slave_responder: WAIT_CYC out of range 0..15");
    end

    resp_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [DATA_W-1:0] wdata_q;
    logic              tdone_q, tdone_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              latch;
    logic              in_range;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_idx;
    logic [DATA_W-1:0] mem_rdata;

    assign in_range = (addr_q >= BASE_ADDR) && (addr_q <= LIMIT_ADDR);

    // In IDLE the RAM is addressed straight from the bus so that even with
    // zero wait states the read data is ready by the ACCESS->DONE edge.
    assign mem_idx = (state_q == IDLE) ? IDX_W'(bus.addr - BASE_ADDR)
                                       : IDX_W'(addr_q - BASE_ADDR);

    g07_slave_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk   (sysClk),
        .we    (mem_we),
        .idx   (mem_idx),
        .wdata (wdata_q),
        .rdata (mem_rdata)
    );

    always_ff @(posedge sysClk or negedge Breset) begin
        if (!Breset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tdone_d = 1'b0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        latch   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.en) begin
                    latch   = 1'b1;
                    cnt_d   = CNT_W'(WAIT_CYC);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (!bus.en) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = DONE;
                    tdone_d = 1'b1;
                    err_d   = !in_range;
                    if (in_range) begin
                        mem_we = rw_q;
                        if (!rw_q) begin
                            rdata_d = mem_rdata;
                        end
                    end else if (!rw_q) begin
                        rdata_d = '1;
                    end
                end
            end
            DONE: begin
                state_d = HOLD;
            end
            HOLD: begin
                // Wait for the arbiter to drop en so one grant is one transaction.
                if (!bus.en) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sysClk or negedge Breset) begin
        if (!Breset) begin
            tdone_q <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
        end else begin
            tdone_q <= tdone_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            if (latch) begin
                addr_q  <= bus.addr;
                rw_q    <= bus.rw;
                wdata_q <= bus.wdata;
            end
        end
    end

    assign bus.Tdone = tdone_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = (state_q != IDLE);

endmodule
